// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: operation encodings and the null producer tag.
package reservation_station_pkg;

  localparam int OP_W = 3;

  // A zero producer tag means the operand value is already present.
  localparam int TAG_NONE = 0;

  typedef enum logic [OP_W-1:0] {
    OP_LW  = 3'b000,
    OP_SW  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_MV  = 3'b100
  } op_e;

endpackage

// File: rtl/reservation_station_select.sv
// Oldest-ready picker: returns the ready entry with the smallest age rank.
module rs_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][IDX_W-1:0] age,
  output logic [IDX_W-1:0]            sel_idx,
  output logic                        sel_valid
);

  logic [IDX_W-1:0] best_age;

  // Ages of busy entries are unique ranks, so a strict less-than never ties.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_valid || (age[i] < best_age))) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age[i];
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station with CDB wakeup, issue-cycle bypass and oldest-ready dispatch.
// Optional macro RS_FLUSH_EN adds a synchronous flush input.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WORD_SIZE = 32,
  parameter int TAG_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef RS_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [OP_W-1:0]            issue_op,
  input  logic [TAG_W-1:0]           issue_dest,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [WORD_SIZE-1:0]       issue_vj,
  input  logic [TAG_W-1:0]           issue_qk,
  input  logic [WORD_SIZE-1:0]       issue_vk,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [WORD_SIZE-1:0]       cdb_value,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [OP_W-1:0]            disp_op,
  output logic [TAG_W-1:0]           disp_dest,
  output logic [WORD_SIZE-1:0]       disp_vj,
  output logic [WORD_SIZE-1:0]       disp_vk,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] TAG_ZERO = TAG_W'(TAG_NONE);

  logic [DEPTH-1:0]            busy_q;
  logic [DEPTH-1:0][IDX_W-1:0] age_q;
  logic [CNT_W-1:0]            count_q;
  logic [OP_W-1:0]             op_q   [DEPTH];
  logic [TAG_W-1:0]            dest_q [DEPTH];
  logic [TAG_W-1:0]            qj_q   [DEPTH];
  logic [TAG_W-1:0]            qk_q   [DEPTH];
  logic [WORD_SIZE-1:0]        vj_q   [DEPTH];
  logic [WORD_SIZE-1:0]        vk_q   [DEPTH];

  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic             issue_fire;
  logic             disp_fire;
  logic             cdb_live;
  logic             hit_j;
  logic             hit_k;
  logic [IDX_W-1:0] new_age;

  always_comb begin
    ready    = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == TAG_ZERO) && (qk_q[i] == TAG_ZERO);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  rs_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .ready     (ready),
    .age       (age_q),
    .sel_idx   (sel_idx),
    .sel_valid (sel_valid)
  );

  assign issue_ready = ~&busy_q;
  assign issue_fire  = issue_valid && issue_ready;
  assign disp_valid  = sel_valid;
  assign disp_fire   = sel_valid && disp_ready;
  assign disp_op     = op_q[sel_idx];
  assign disp_dest   = dest_q[sel_idx];
  assign disp_vj     = vj_q[sel_idx];
  assign disp_vk     = vk_q[sel_idx];
  assign count       = count_q;

  assign cdb_live = cdb_valid && (cdb_tag != TAG_ZERO);
  assign hit_j    = cdb_live && (issue_qj == cdb_tag);
  assign hit_k    = cdb_live && (issue_qk == cdb_tag);

  // A new entry is the youngest of the survivors, so it ranks behind everything still busy.
  assign new_age = IDX_W'(count_q - CNT_W'(disp_fire));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      age_q   <= '0;
      count_q <= '0;
    end
`ifdef RS_FLUSH_EN
    else if (flush) begin
      busy_q  <= '0;
      age_q   <= '0;
      count_q <= '0;
    end
`endif
    else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (disp_fire && (IDX_W'(i) == sel_idx)) begin
          busy_q[i] <= 1'b0;
          age_q[i]  <= '0;
        end else if (disp_fire && busy_q[i] && (age_q[i] > age_q[sel_idx])) begin
          age_q[i] <= age_q[i] - IDX_W'(1);
        end
      end
      if (issue_fire) begin
        busy_q[free_idx] <= 1'b1;
        age_q[free_idx]  <= new_age;
      end
      case ({issue_fire, disp_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && cdb_live) begin
        if (qj_q[i] == cdb_tag) begin
          vj_q[i] <= cdb_value;
          qj_q[i] <= TAG_ZERO;
        end
        if (qk_q[i] == cdb_tag) begin
          vk_q[i] <= cdb_value;
          qk_q[i] <= TAG_ZERO;
        end
      end
    end
    if (issue_fire) begin
      op_q[free_idx]   <= issue_op;
      dest_q[free_idx] <= issue_dest;
      qj_q[free_idx]   <= hit_j ? TAG_ZERO : issue_qj;
      vj_q[free_idx]   <= hit_j ? cdb_value : issue_vj;
      qk_q[free_idx]   <= hit_k ? TAG_ZERO : issue_qk;
      vk_q[free_idx]   <= hit_k ? cdb_value : issue_vk;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: vector table plus scoreboarded multi-cycle sequences.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int DEPTH     = 4;
  localparam int WORD_SIZE = 32;
  localparam int TAG_W     = 4;

  logic        clk;
  logic        rst;
`ifdef RS_FLUSH_EN
  logic        flush;
`endif
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_op;
  logic [3:0]  issue_dest;
  logic [3:0]  issue_qj;
  logic [31:0] issue_vj;
  logic [3:0]  issue_qk;
  logic [31:0] issue_vk;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        disp_valid;
  logic        disp_ready;
  logic [2:0]  disp_op;
  logic [3:0]  disp_dest;
  logic [31:0] disp_vj;
  logic [31:0] disp_vk;
  logic [2:0]  count;

  reservation_station #(
    .DEPTH     (DEPTH),
    .WORD_SIZE (WORD_SIZE),
    .TAG_W     (TAG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef RS_FLUSH_EN
    .flush       (flush),
`endif
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_dest  (issue_dest),
    .issue_qj    (issue_qj),
    .issue_vj    (issue_vj),
    .issue_qk    (issue_qk),
    .issue_vk    (issue_vk),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_op     (disp_op),
    .disp_dest   (disp_dest),
    .disp_vj     (disp_vj),
    .disp_vk     (disp_vk),
    .count       (count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  dest;
    logic [31:0] vj;
    logic [31:0] vk;
  } disp_t;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  dest;
    logic [3:0]  qj;
    logic [31:0] vj;
    logic [3:0]  qk;
    logic [31:0] vk;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cval;
    logic [31:0] evj;
    logic [31:0] evk;
  } vec_t;

  disp_t exp_q[$];
  disp_t mon_e;
  vec_t  vecs[7];
  int    errors = 0;
  int    checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [2:0] op, input logic [3:0] dest, input logic [31:0] vj, input logic [31:0] vk);
    disp_t e;
    e.op   = op;
    e.dest = dest;
    e.vj   = vj;
    e.vk   = vk;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] dest, input logic [3:0] qj,
                               input logic [31:0] vj, input logic [3:0] qk, input logic [31:0] vk,
                               input logic cv, input logic [3:0] ct, input logic [31:0] cval);
    checkOutput("issue_ready_before_issue", {31'b0, issue_ready}, 32'd1);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_dest  = dest;
    issue_qj    = qj;
    issue_vj    = vj;
    issue_qk    = qk;
    issue_vk    = vk;
    cdb_valid   = cv;
    cdb_tag     = ct;
    cdb_value   = cval;
    tick();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
  endtask

  task automatic driveCdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = val;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("drain_pending", exp_q.size(), 32'd0);
  endtask

  // Scoreboard: every handshake pops the next expected dispatch.
  always @(negedge clk) begin
    if (!rst && disp_valid && disp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_dispatch: actual dest=%0d expected none", disp_dest);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("disp_op", {29'b0, disp_op}, {29'b0, mon_e.op});
        checkOutput("disp_dest", {28'b0, disp_dest}, {28'b0, mon_e.dest});
        checkOutput("disp_vj", disp_vj, mon_e.vj);
        checkOutput("disp_vk", disp_vk, mon_e.vk);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{OP_ADD, 4'd3,  4'd0, 32'd5,        4'd0, 32'd7, 1'b0, 4'd0, 32'd0,        32'd5,        32'd7};
    vecs[1] = '{OP_LW,  4'd1,  4'd0, 32'd100,      4'd0, 32'd8, 1'b0, 4'd0, 32'd0,        32'd100,      32'd8};
    vecs[2] = '{OP_ADD, 4'd2,  4'd6, 32'd0,        4'd0, 32'd1, 1'b1, 4'd6, 32'd11,       32'd11,       32'd1};
    vecs[3] = '{OP_SW,  4'd4,  4'd0, 32'd3,        4'd5, 32'd0, 1'b1, 4'd5, 32'hdeadbeef, 32'd3,        32'hdeadbeef};
    vecs[4] = '{OP_MUL, 4'd7,  4'd9, 32'd0,        4'd9, 32'd0, 1'b1, 4'd9, 32'd42,       32'd42,       32'd42};
    vecs[5] = '{OP_MV,  4'd15, 4'd0, 32'hffffffff, 4'd0, 32'd0, 1'b1, 4'd3, 32'd99,       32'hffffffff, 32'd0};
    vecs[6] = '{OP_ADD, 4'd6,  4'd0, 32'd12,       4'd0, 32'd34, 1'b1, 4'd0, 32'd77,      32'd12,       32'd34};

    rst = 1'b1;
`ifdef RS_FLUSH_EN
    flush = 1'b0;
`endif
    issue_valid = 1'b0; issue_op = '0; issue_dest = '0; issue_qj = '0; issue_vj = '0;
    issue_qk = '0; issue_vk = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; disp_ready = 1'b0;
    #1;
    checkOutput("reset_count", {29'b0, count}, 32'd0);
    checkOutput("reset_issue_ready", {31'b0, issue_ready}, 32'd1);
    checkOutput("reset_disp_valid", {31'b0, disp_valid}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single independent issues, including issue-cycle bypass and tag-0 CDB.
    disp_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      pushExp(vecs[v].op, vecs[v].dest, vecs[v].evj, vecs[v].evk);
      applyStimulus(vecs[v].op, vecs[v].dest, vecs[v].qj, vecs[v].vj, vecs[v].qk, vecs[v].vk,
                    vecs[v].cv, vecs[v].ct, vecs[v].cval);
      checkOutput("vec_count_after_issue", {29'b0, count}, 32'd1);
      checkOutput("vec_disp_valid", {31'b0, disp_valid}, 32'd1);
      tick();
      checkOutput("vec_count_after_disp", {29'b0, count}, 32'd0);
      checkOutput("vec_disp_idle", {31'b0, disp_valid}, 32'd0);
    end

    // Issue and dispatch in the same cycle.
    pushExp(OP_ADD, 4'd6, 32'd1, 32'd2);
    pushExp(OP_LW,  4'd7, 32'd3, 32'd4);
    applyStimulus(OP_ADD, 4'd6, 4'd0, 32'd1, 4'd0, 32'd2, 1'b0, 4'd0, 32'd0);
    checkOutput("simul_count_before", {29'b0, count}, 32'd1);
    applyStimulus(OP_LW, 4'd7, 4'd0, 32'd3, 4'd0, 32'd4, 1'b0, 4'd0, 32'd0);
    checkOutput("simul_count_same", {29'b0, count}, 32'd1);
    tick();
    checkOutput("simul_count_end", {29'b0, count}, 32'd0);

    // Wakeup from a later CDB broadcast.
    pushExp(OP_MUL, 4'd5, 32'd9, 32'd4);
    applyStimulus(OP_MUL, 4'd5, 4'd2, 32'd0, 4'd0, 32'd4, 1'b0, 4'd0, 32'd0);
    checkOutput("wake_wait0", {31'b0, disp_valid}, 32'd0);
    tick();
    checkOutput("wake_wait1", {31'b0, disp_valid}, 32'd0);
    driveCdb(4'd2, 32'd9);
    checkOutput("wake_valid", {31'b0, disp_valid}, 32'd1);
    tick();
    checkOutput("wake_count", {29'b0, count}, 32'd0);

    // Stall with two ready entries, then an older entry wakes and takes over.
    disp_ready = 1'b0;
    applyStimulus(OP_MUL, 4'd8, 4'd4, 32'd0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0);
    applyStimulus(OP_ADD, 4'd9, 4'd0, 32'd2, 4'd0, 32'd3, 1'b0, 4'd0, 32'd0);
    checkOutput("stall_sel_e", {28'b0, disp_dest}, 32'd9);
    applyStimulus(OP_MV, 4'd10, 4'd0, 32'd4, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("stall_dest", {28'b0, disp_dest}, 32'd9);
      checkOutput("stall_vj", disp_vj, 32'd2);
      tick();
    end
    driveCdb(4'd4, 32'd44);
    checkOutput("older_takes_over", {28'b0, disp_dest}, 32'd8);
    pushExp(OP_MUL, 4'd8, 32'd44, 32'd1);
    pushExp(OP_ADD, 4'd9, 32'd2, 32'd3);
    pushExp(OP_MV, 4'd10, 32'd4, 32'd5);
    disp_ready = 1'b1;
    waitDrain();
    checkOutput("stall_count_end", {29'b0, count}, 32'd0);

    // A reused low slot must still rank younger than a surviving higher slot.
    pushExp(OP_ADD, 4'd11, 32'd21, 32'd0);
    applyStimulus(OP_ADD, 4'd11, 4'd1, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(OP_SW, 4'd12, 4'd2, 32'd0, 4'd0, 32'd6, 1'b0, 4'd0, 32'd0);
    driveCdb(4'd1, 32'd21);
    tick();
    disp_ready = 1'b0;
    applyStimulus(OP_LW, 4'd13, 4'd3, 32'd0, 4'd0, 32'd7, 1'b0, 4'd0, 32'd0);
    driveCdb(4'd3, 32'd23);
    driveCdb(4'd2, 32'd22);
    checkOutput("age_older_slot", {28'b0, disp_dest}, 32'd12);
    pushExp(OP_SW, 4'd12, 32'd22, 32'd6);
    pushExp(OP_LW, 4'd13, 32'd23, 32'd7);
    disp_ready = 1'b1;
    waitDrain();
    checkOutput("age_count_end", {29'b0, count}, 32'd0);

    // Fill all entries, wake entry 2, then reset with three entries resident.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(OP_ADD, 4'(i + 1), 4'(i + 7), 32'd0, 4'd0, 32'(i + 1), 1'b0, 4'd0, 32'd0);
    end
    checkOutput("full_count", {29'b0, count}, 32'd4);
    checkOutput("full_issue_ready", {31'b0, issue_ready}, 32'd0);
    pushExp(OP_ADD, 4'd3, 32'd55, 32'd3);
    driveCdb(4'd9, 32'd55);
    checkOutput("full_wake_valid", {31'b0, disp_valid}, 32'd1);
    checkOutput("full_wake_dest", {28'b0, disp_dest}, 32'd3);
    tick();
    checkOutput("after_free_issue_ready", {31'b0, issue_ready}, 32'd1);
    checkOutput("after_free_count", {29'b0, count}, 32'd3);
    disp_ready = 1'b0;
    driveCdb(4'd7, 32'd66);
    checkOutput("pre_reset_valid", {31'b0, disp_valid}, 32'd1);
    checkOutput("pre_reset_dest", {28'b0, disp_dest}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_count", {29'b0, count}, 32'd0);
    checkOutput("midreset_disp_valid", {31'b0, disp_valid}, 32'd0);
    checkOutput("midreset_issue_ready", {31'b0, issue_ready}, 32'd1);
    disp_ready = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("release_disp_valid", {31'b0, disp_valid}, 32'd0);
    tick();
    checkOutput("post_reset_disp_valid", {31'b0, disp_valid}, 32'd0);
    checkOutput("post_reset_count", {29'b0, count}, 32'd0);

`ifdef RS_FLUSH_EN
    disp_ready = 1'b0;
    applyStimulus(OP_ADD, 4'd1, 4'd3, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    applyStimulus(OP_ADD, 4'd2, 4'd4, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    checkOutput("preflush_count", {29'b0, count}, 32'd2);
    flush = 1'b1;
    issue_valid = 1'b1; issue_op = OP_ADD; issue_dest = 4'd5; issue_qj = 4'd0; issue_qk = 4'd0;
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    checkOutput("flush_count", {29'b0, count}, 32'd0);
    checkOutput("flush_disp_valid", {31'b0, disp_valid}, 32'd0);
    checkOutput("flush_issue_ready", {31'b0, issue_ready}, 32'd1);
`endif

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
